// File: rtl/nv_fifo_rws_pkg.sv
// nv_fifo_rws_pkg: shared geometry and payload type for the 64x18 RAM-backed FIFO
package nv_fifo_rws_pkg;
  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_WIDTH = 18;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_CW    = FIFO_AW + 1;
  typedef logic [FIFO_WIDTH-1:0] payload_t;
endpackage

// File: rtl/nv_ram_rws_64x18.sv
// nv_ram_rws_64x18: 64x18 RAM, sync write, registered read data one cycle after re
module nv_ram_rws_64x18
  import nv_fifo_rws_pkg::*;
(
  input  logic                 clk,
  input  logic [FIFO_AW-1:0]   ra,
  input  logic                 re,
  output payload_t             dout,
  input  logic [FIFO_AW-1:0]   wa,
  input  logic                 we,
  input  payload_t             di,
  input  logic [31:0]          pwrbus_ram_pd
);
  payload_t mem [FIFO_DEPTH];
  logic pwr_unused;
  assign pwr_unused = ^pwrbus_ram_pd;
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) dout <= mem[ra];
  end
endmodule

// File: rtl/nv_fifo_rws_64x18_ctrl.sv
// nv_fifo_rws_64x18_ctrl: valid/ready FIFO over one nv_ram_rws_64x18 with a 2-entry output skid
// Optional RAM bypass into the output stage when NV_FIFO_RWS_64X18_BYPASS_EN is defined.
module nv_fifo_rws_64x18_ctrl
  import nv_fifo_rws_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW:0]      count,
  input  logic [31:0]      pwrbus_ram_pd
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] ram_cnt, ram_cnt_n, total, total_n;
  logic [WIDTH-1:0] head, skid, dout, head_n, skid_n, ins_d;
  logic inflight, head_vld, skid_vld, head_vld_n, skid_vld_n;
  logic push, pop, re, we, byp, ins, h_v, s_v;
  logic [2:0] occ;
  always_comb begin
    push = wr_pvld & wr_prdy;
    pop = head_vld & rd_prdy;
    occ = 3'(head_vld) + 3'(skid_vld) + 3'(inflight) - 3'(pop);
    re = (ram_cnt != '0) && (occ < 3'd2);
`ifdef NV_FIFO_RWS_64X18_BYPASS_EN
    byp = push && (ram_cnt == '0) && !inflight && (occ < 3'd2);
`else
    byp = 1'b0;
`endif
    we = push & ~byp;
    h_v = pop ? skid_vld : head_vld;
    s_v = skid_vld & ~pop;
    ins = inflight | byp;
    ins_d = inflight ? dout : wr_pd;
    head_n = (ins && !h_v) ? ins_d : (pop ? skid : head);
    skid_n = (ins && h_v) ? ins_d : skid;
    head_vld_n = h_v | ins;
    skid_vld_n = s_v | (ins & h_v);
    ram_cnt_n = ram_cnt + (AW+1)'(we) - (AW+1)'(re);
    total = ram_cnt + (AW+1)'(inflight) + (AW+1)'(head_vld) + (AW+1)'(skid_vld);
    total_n = total + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      inflight <= 1'b0;
      head <= '0;
      skid <= '0;
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
      wr_prdy <= 1'b0;
    end else begin
      wr_ptr <= we ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= re ? rd_ptr + AW'(1) : rd_ptr;
      ram_cnt <= ram_cnt_n;
      inflight <= re;
      head <= head_n;
      skid <= skid_n;
      head_vld <= head_vld_n;
      skid_vld <= skid_vld_n;
      wr_prdy <= total_n < (AW+1)'(DEPTH);
    end
  end
  assign rd_pvld = head_vld;
  assign rd_pd = head;
  assign count = total;
  nv_ram_rws_64x18 u_ram (
    .clk           (clk),
    .ra            (rd_ptr),
    .re            (re),
    .dout          (dout),
    .wa            (wr_ptr),
    .we            (we),
    .di            (wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );
endmodule

// File: tb/tb_nv_fifo_rws_64x18_ctrl.sv
// tb_nv_fifo_rws_64x18_ctrl: scoreboard bench for the 64x18 valid/ready FIFO controller
module tb_nv_fifo_rws_64x18_ctrl;
`ifdef NV_FIFO_RWS_64X18_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif
  logic clk, rst, wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [17:0] wr_pd, rd_pd;
  logic [6:0] count;
  logic [31:0] pwrbus_ram_pd;
  int checks, errors, pops;
  logic [17:0] q[$];
  logic stall;
  logic [17:0] stall_pd;

  nv_fifo_rws_64x18_ctrl dut (
    .clk(clk), .rst(rst), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd), .count(count),
    .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      chk("count_vs_model", 32'(count), 32'(q.size()));
      if (stall && rd_pvld) chk("hold_pd", 32'(rd_pd), 32'(stall_pd));
      if (rd_pvld && rd_prdy) begin
        pops++;
        if (q.size() == 0) chk("underflow", 32'(rd_pd), 32'hFFFF_FFFF);
        else chk("data", 32'(rd_pd), 32'(q.pop_front()));
      end
      if (wr_pvld && wr_prdy) q.push_back(wr_pd);
      stall = rd_pvld & !rd_prdy;
      stall_pd = rd_pd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_to(input int target, input int base);
    int i, n;
    logic acc;
    i = 0;
    n = 0;
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    wr_pd = 18'(base);
    while (32'(count) < target && n < 300) begin
      acc = wr_prdy;
      tick();
      if (acc) i++;
      wr_pd = 18'(base + i);
      n++;
    end
    wr_pvld = 1'b0;
    chk("fill_count", 32'(count), 32'(target));
  endtask

  task automatic drain();
    int n;
    n = 0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    while (count != 0 && n < 500) begin
      tick();
      n++;
    end
    rd_prdy = 1'b0;
    chk("drain_count", 32'(count), 0);
  endtask

  initial begin
    int n, p0;
    checks = 0; errors = 0; pops = 0;
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0; pwrbus_ram_pd = '0;
    #12;
    chk("rst_wr_prdy", 32'(wr_prdy), 0);
    chk("rst_rd_pvld", 32'(rd_pvld), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_pd", 32'(rd_pd), 0);
    #11 rst = 1'b0;
    tick();
    chk("prdy_after_rst", 32'(wr_prdy), 1);

    // single push latency
    wr_pvld = 1'b1; wr_pd = 18'h2A5A5;
    tick();
    wr_pvld = 1'b0;
    n = 1;
    while (!rd_pvld && n < 10) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("single_pd", 32'(rd_pd), 32'h2A5A5);
    chk("single_cnt1", 32'(count), 1);
    rd_prdy = 1'b1;
    tick();
    rd_prdy = 1'b0;
    chk("single_cnt0", 32'(count), 0);

    // fill 0..63, overflow attempt, drain in order
    fill_to(64, 0);
    chk("full_prdy", 32'(wr_prdy), 0);
    wr_pvld = 1'b1; wr_pd = 18'd999;
    repeat (3) tick();
    wr_pvld = 1'b0;
    chk("full_65th", 32'(count), 64);
    p0 = pops;
    drain();
    chk("drain_pops", 32'(pops - p0), 64);

    // continuous stream, wraps pointers several times
    p0 = pops;
    for (int i = 0; i < 200; i++) begin
      wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 18'(1000 + i);
      tick();
    end
    wr_pvld = 1'b0;
    chk("stream_pops", 32'(pops - p0), 32'(200 - LAT));
    chk("stream_count", 32'(count), 32'(LAT));
    drain();

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      wr_pvld = 1'($urandom_range(1));
      rd_prdy = 1'($urandom_range(1));
      wr_pd = 18'($urandom);
      tick();
    end
    drain();

    // full with push and pop both held: first pop drops to 63, then push+pop keeps it there
    fill_to(64, 2000);
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 18'd3000;
    tick();
    chk("pop_raises_prdy", 32'(wr_prdy), 1);
    chk("full_pop_count", 32'(count), 63);
    for (int i = 1; i < 20; i++) begin
      wr_pd = 18'(3000 + i);
      tick();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    chk("full_hold_count", 32'(count), 63);
    drain();

    // asynchronous reset mid-stream
    fill_to(37, 5000);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_pvld", 32'(rd_pvld), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_prdy", 32'(wr_prdy), 0);
    #3 rst = 1'b0;
    tick();
    chk("post_rst_prdy", 32'(wr_prdy), 1);
    p0 = pops;
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 18'h00001;
    tick();
    wr_pvld = 1'b0;
    repeat (5) tick();
    rd_prdy = 1'b0;
    chk("post_rst_pops", 32'(pops - p0), 1);
    chk("sb_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
